systolic_array_ctrl: RTL
========================

Name: systolic_array_ctrl

Overview:
Sequencer for one tile operation on the ROWS x COLS systolic PE array.
- Drives the array's prefill and os_en controls.
- Generates read strobes and addresses for the weight and activation operand buffers, and write strobes for the result buffer.
- Uses a start/busy/done handshake toward the layer scheduler.
- Supports weight-stationary (WS) and output-stationary (OS) dataflows, selected per operation.

Parameters:
ROWS, 32, array rows; also the number of weight rows prefetched in WS mode.
COLS, 32, array columns.
K_W, 16, width of the k_len operand-count field.
ADDR_W, 10, width of all buffer address outputs.
LAT, ROWS+COLS, cycles from activation read strobe to the corresponding valid bottom_out_bus word (buffer read latency plus skew).

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
start  in  1  request a tile operation; sampled only in IDLE
os_mode  in  1  0 = WS, 1 = OS; sampled with start
k_len  in  K_W  number of activation vectors; sampled with start
busy  out  1  high from the cycle after start is accepted until the last write cycle
done  out  1  one-cycle completion pulse
prefill  out  1  array prefill control
os_en  out  1  array output-stationary enable
w_rd_en  out  1  weight buffer read strobe
w_rd_addr  out  ADDR_W  weight buffer address
a_rd_en  out  1  activation buffer read strobe
a_rd_addr  out  ADDR_W  activation buffer address
out_wr_en  out  1  result buffer write strobe
out_wr_addr  out  ADDR_W  result buffer address

Behaviour:
- FSM states: IDLE, PREFILL, STREAM, FLUSH, UNLOAD, DRAIN, DONE. All outputs are registered.
- Reset: state = IDLE; every output = 0; all counters = 0. A reset asserted mid-operation aborts it: no done pulse, and the next cycle is IDLE with all outputs 0.
- Cycle numbering: cycle 0 is the first cycle after start is accepted.
- IDLE:
  - start=1 latches os_mode and k_len.
  - k_len=0 goes to DONE: no strobes, busy stays 0, done pulses at cycle 0.
  - Otherwise the next state is PREFILL (WS) or STREAM (OS).
- WS PREFILL: ROWS cycles.
  - prefill=1, w_rd_en=1.
  - w_rd_addr counts ROWS-1 down to 0 (bottom row loaded first).
  - Then go to STREAM.
- WS STREAM: k_len cycles.
  - a_rd_en=1; a_rd_addr counts 0..k_len-1; prefill=0.
  - Then go to DRAIN.
- WS writes:
  - out_wr_en is a_rd_en delayed exactly LAT cycles (shift register or counter).
  - out_wr_addr starts at 0 and increments after each write.
  - DRAIN holds until the last write; DONE follows.
- OS STREAM: k_len cycles.
  - os_en=1, w_rd_en=1, a_rd_en=1.
  - Both read addresses count 0..k_len-1.
- OS FLUSH: ROWS+COLS-1 cycles with os_en=1 and no reads.
- OS UNLOAD: ROWS cycles.
  - os_en=0, prefill=1 (shifts accumulators down).
  - out_wr_en=1; out_wr_addr counts 0..ROWS-1.
  - Then go to DONE.
- DONE: done=1, busy=0 for one cycle, then IDLE. start is ignored in DONE and in every non-IDLE state; no queuing.
- Address counters wrap modulo 2^ADDR_W. k_len above 2^ADDR_W is not checked; the address wraps.
- prefill and os_en are never both 1 except during OS UNLOAD transition? No: they are mutually exclusive in every cycle.

Optional Feature:
Macro SA_CTRL_PERF_EN.
- Defined: adds output perf_cycles (32 bits). It counts busy cycles of the current operation, saturates at 0xFFFFFFFF, holds its value after done, clears to 0 on the next accepted start, and reads 0 after reset.
- Undefined: the port and counter are absent.

Test Plan:
- ROWS=COLS=4, WS, k_len=3:
  - prefill=1 in cycles 0-3, w_rd_addr 3,2,1,0.
  - a_rd_en in cycles 4-6, addr 0,1,2.
  - out_wr_en in cycles 12-14, addr 0,1,2.
  - done at cycle 15; busy=1 in cycles 0-14.
- ROWS=COLS=4, OS, k_len=3:
  - os_en=1 in cycles 0-9; reads in cycles 0-2.
  - prefill=1 and out_wr_en in cycles 10-13, addr 0..3.
  - done at cycle 14; prefill and os_en never overlap.
- k_len=0 with start: done pulses at cycle 0; no strobes; busy stays 0.
- start pulsed during WS STREAM and during DONE: ignored. A start in the IDLE cycle after done begins a new operation with addresses restarting at 0.
- rst asserted at cycle 5 of a WS op with k_len=3: outputs 0 the next cycle, no done, no further writes. A following start runs a clean operation.
- SA_CTRL_PERF_EN defined, WS k_len=3 case above: perf_cycles=15 after done, and 0 after the next start.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Tile-operation sequencer for the ROWS x COLS systolic PE array (WS and OS dataflows).
// Optional feature: define SA_CTRL_PERF_EN to add the perf_cycles busy-cycle counter output.
module systolic_array_ctrl #(
    parameter int unsigned ROWS   = 32,
    parameter int unsigned COLS   = 32,
    parameter int unsigned K_W    = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LAT    = ROWS + COLS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              os_mode,
    input  logic [K_W-1:0]    k_len,
    output logic              busy,
    output logic              done,
    output logic              prefill,
    output logic              os_en,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_rd_addr,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr
`ifdef SA_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam int unsigned SR_W     = LAT - 1;
    localparam int unsigned CLOG_RC  = $clog2(ROWS + COLS) + 1;
    localparam int unsigned CNT_W    = (K_W > CLOG_RC) ? K_W : CLOG_RC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_STREAM,
        S_FLUSH,
        S_UNLOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic              os_mode_q;
    logic [K_W-1:0]    k_len_q;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   wr_pipe;
    logic              stream_last;

    assign stream_last = (cnt + CNT_W'(1)) == CNT_W'(k_len_q);

    // Sequencer; outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            os_mode_q   <= 1'b0;
            k_len_q     <= '0;
            cnt         <= '0;
            wr_pipe     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            prefill     <= 1'b0;
            os_en       <= 1'b0;
            w_rd_en     <= 1'b0;
            w_rd_addr   <= '0;
            a_rd_en     <= 1'b0;
            a_rd_addr   <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
        end else begin
            // WS result writes trail the activation reads by exactly LAT cycles.
            wr_pipe     <= (wr_pipe << 1) | SR_W'(a_rd_en & ~os_mode_q);
            out_wr_en   <= wr_pipe[SR_W-1];
            out_wr_addr <= out_wr_addr + ADDR_W'(out_wr_en);
            done        <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        os_mode_q   <= os_mode;
                        k_len_q     <= k_len;
                        cnt         <= '0;
                        out_wr_addr <= '0;
                        w_rd_addr   <= '0;
                        a_rd_addr   <= '0;
                        if (k_len == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else if (os_mode) begin
                            state   <= S_STREAM;
                            busy    <= 1'b1;
                            os_en   <= 1'b1;
                            w_rd_en <= 1'b1;
                            a_rd_en <= 1'b1;
                        end else begin
                            state     <= S_PREFILL;
                            busy      <= 1'b1;
                            prefill   <= 1'b1;
                            w_rd_en   <= 1'b1;
                            w_rd_addr <= ADDR_W'(ROWS - 1);
                        end
                    end
                end

                // Bottom weight row is fetched first so it lands deepest in the array.
                S_PREFILL: begin
                    if (cnt == CNT_W'(ROWS - 1)) begin
                        state     <= S_STREAM;
                        cnt       <= '0;
                        prefill   <= 1'b0;
                        w_rd_en   <= 1'b0;
                        w_rd_addr <= '0;
                        a_rd_en   <= 1'b1;
                        a_rd_addr <= '0;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        w_rd_addr <= w_rd_addr - ADDR_W'(1);
                    end
                end

                S_STREAM: begin
                    if (stream_last) begin
                        cnt       <= '0;
                        a_rd_en   <= 1'b0;
                        a_rd_addr <= '0;
                        w_rd_en   <= 1'b0;
                        w_rd_addr <= '0;
                        state     <= os_mode_q ? S_FLUSH : S_DRAIN;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        a_rd_addr <= a_rd_addr + ADDR_W'(1);
                        if (os_mode_q) begin
                            w_rd_addr <= w_rd_addr + ADDR_W'(1);
                        end
                    end
                end

                // Let the last operands ripple through to the far corner PE.
                S_FLUSH: begin
                    if (cnt == CNT_W'(ROWS + COLS - 2)) begin
                        state     <= S_UNLOAD;
                        cnt       <= '0;
                        os_en     <= 1'b0;
                        prefill   <= 1'b1;
                        out_wr_en <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                S_UNLOAD: begin
                    if (cnt == CNT_W'(ROWS - 1)) begin
                        state     <= S_DONE;
                        cnt       <= '0;
                        prefill   <= 1'b0;
                        out_wr_en <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        out_wr_en <= 1'b1;
                    end
                end

                // Last write is the one with nothing left in the latency pipe.
                S_DRAIN: begin
                    if (out_wr_en && (wr_pipe == '0)) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SA_CTRL_PERF_EN
    // Busy-cycle counter: saturating, held after done, cleared by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if ((state == S_IDLE) && start) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
